master_port: RTL and testbench
==============================

Name: master_port

Overview:
- Initiator end of the serial system-bus link; drives the responder port's swdata/smode/mvalid inputs and consumes its srdata/svalid outputs.
- Accepts one parallel read or write request from a local bus master and serialises it MSB-first: 12-bit address, then 8-bit write data on writes.
- On reads, deserialises 8 returned bits into a parallel word.
- Reports completion, and a timeout error if the responder never answers.

Parameters:
ADDR_WIDTH, 12, serial address length in bits
DATA_WIDTH, 8, data word length in bits
TIMEOUT, 64, max cycles in RWAIT before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
dreq  in  1  local request strobe, sampled only when dready=1
dmode  in  1  0 read, 1 write
daddr  in  ADDR_WIDTH  request address
dwdata  in  DATA_WIDTH  write data
dready  out  1  high only in IDLE
drdata  out  DATA_WIDTH  last successful read word
drvalid  out  1  one-cycle pulse, drdata updated
dack  out  1  one-cycle pulse, transaction finished
derr  out  1  one-cycle pulse with dack, read timed out/aborted
mwdata  out  1  serial address/write-data bit (to responder swdata)
mmode  out  1  mode to responder (to smode)
mvalid  out  1  serial bit valid (to responder mvalid)
srdata  in  1  serial read-data bit from responder
svalid  in  1  read bit valid from responder

Behaviour:
- Reset (rst=1 at edge): state IDLE. dready=1, mvalid=0, mwdata=0, mmode=0, drdata=0, drvalid=0, dack=0, derr=0. Counters 0. Reset mid-transaction aborts immediately: mvalid=0 after that edge, no dack.
- States: IDLE, ADDR, WDATA, RWAIT, RDATA, DONE. All outputs are registered.
- IDLE:
  - dreq=1 at edge T latches daddr, dwdata and dmode. Go to ADDR, dready=0.
  - dreq is ignored in every other state; no queueing.
- ADDR:
  - Cycles T+1..T+ADDR_WIDTH: mvalid=1, mmode=latched mode, mwdata=addr[ADDR_WIDTH-1-k] on bit k.
  - After the last bit: write -> WDATA; read -> RWAIT.
- WDATA: next DATA_WIDTH cycles: mvalid=1, mwdata=wdata MSB first. Then DONE.
- Write latency: mvalid high exactly ADDR_WIDTH+DATA_WIDTH contiguous cycles; dack at T+ADDR_WIDTH+DATA_WIDTH+1.
- RWAIT:
  - mvalid=0, mwdata=0, mmode held at 0. Timeout counter increments each cycle.
  - svalid=1: capture srdata as bit DATA_WIDTH-1 and go to RDATA.
  - Counter reaches TIMEOUT with no svalid: DONE with error.
- RDATA:
  - Capture the remaining DATA_WIDTH-1 bits, MSB first, one per cycle while svalid=1.
  - svalid=0 before the word completes: abort to DONE with error, discard the partial word.
- DONE (1 cycle):
  - dack=1.
  - Read success: drdata<=shift register and drvalid=1, same cycle as dack.
  - Error: derr=1 and drdata unchanged.
  - Next state IDLE; dready=1 the following cycle.
- Back-to-back: minimum gap between transactions is one IDLE cycle, so mvalid is low for at least 2 cycles between bursts.
- svalid=1 outside RWAIT/RDATA: ignored.
- Counters are sized $clog2 of their maximum and never wrap: cleared on state entry, saturating compare.

Decomposition:
- Shared package master_port_pkg: state encoding localparams (IDLE..DONE), mode constants MODE_READ=0 and MODE_WRITE=1, default widths 12/8.
- One natural sub-module: piso_sipo_shift (parameter WIDTH; load, shift-out, shift-in, MSB first), instantiated twice: address+write-data TX shifter, read-data RX shifter.
- FSM and counters stay in master_port.

Test Plan:
- Write daddr=12'h5AB, dwdata=8'hAA: mvalid high 20 cycles, mwdata=0101_1010_1011 then 1010_1010, mmode=1 throughout, dack at T+21, derr=0.
- Read daddr=12'h5AB, responder answers svalid after 5 cycles with 8'hCC MSB first: mwdata shows the 12 address bits with mmode=0, then drdata=8'hCC, drvalid=dack=1 in the same cycle.
- Read with svalid never asserted, TIMEOUT=64: dack=derr=1 exactly 64 cycles after address end, drdata keeps its previous value (8'hCC), dready=1 the next cycle.
- Read where svalid drops after 4 bits: derr=1, drvalid=0, drdata unchanged.
- Assert rst mid-WDATA, at bit 3: next edge mvalid=0, dready=1, no dack. A following write of 12'h001/8'h01 completes normally.
- Two writes with dreq held high: the second accepted one cycle after dack; the mvalid low gap is 2 cycles; dreq during the busy states is ignored.

Source files
------------

// File: rtl/master_port_pkg.sv
// Shared types and constants for the serial bus initiator port.
package master_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RWAIT,
    RDATA,
    DONE
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int TIMEOUT_DEF    = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/master_port_if.sv
// Local request bus plus serial link signals of the initiator port.
interface master_port_if
  import master_port_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  dreq;
  logic                  dmode;
  logic [ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0] dwdata;
  logic                  dready;
  logic [DATA_WIDTH-1:0] drdata;
  logic                  drvalid;
  logic                  dack;
  logic                  derr;
  logic                  mwdata;
  logic                  mmode;
  logic                  mvalid;
  logic                  srdata;
  logic                  svalid;

  modport master (
    input  dreq, dmode, daddr, dwdata, srdata, svalid,
    output dready, drdata, drvalid, dack, derr, mwdata, mmode, mvalid
  );

  modport slave (
    output dreq, dmode, daddr, dwdata, srdata, svalid,
    input  dready, drdata, drvalid, dack, derr, mwdata, mmode, mvalid
  );

endinterface

// File: rtl/piso_sipo_shift.sv
// MSB-first shift register: parallel load, serial shift-in at the LSB,
// serial out taken from the MSB.
module piso_sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             shift_in,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {data[WIDTH-2:0], shift_in};
    end
  end

endmodule

// File: rtl/master_port.sv
// Serial bus initiator: serialises one read/write request, collects the
// read word, and reports completion or a responder timeout.
module master_port
  import master_port_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  master_port_if.master   bus
);

  localparam int TX_W    = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int CNT_MAX = max3(ADDR_WIDTH, DATA_WIDTH, TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  mode_q;
  logic                  dready_q;
  logic                  mvalid_q;
  logic                  mmode_q;
  logic [DATA_WIDTH-1:0] drdata_q;
  logic                  drvalid_q;
  logic                  dack_q;
  logic                  derr_q;

  logic [TX_W-1:0]       tx_data;
  logic [DATA_WIDTH-2:0] rx_data;
  logic                  start;
  logic                  addr_end;
  logic                  tx_last;
  logic                  tx_load;
  logic [TX_W-1:0]       tx_load_data;
  logic                  tx_shift;
  logic                  rx_shift;

  // A marker bit trails the write data, so the final data bit is on the
  // wire exactly when everything below the MSB is the lone marker.
  assign start        = (state == IDLE) && bus.dreq;
  assign addr_end     = (state == ADDR) && (cnt == CNT_W'(ADDR_WIDTH - 1));
  assign tx_last      = (tx_data[TX_W-2:0] == {1'b1, {(TX_W-2){1'b0}}});
  assign tx_load      = start || (addr_end && (mode_q == MODE_READ)) ||
                        ((state == WDATA) && tx_last);
  assign tx_load_data = start ? {bus.daddr,
                                 (bus.dmode == MODE_WRITE) ? bus.dwdata : {DATA_WIDTH{1'b0}},
                                 1'b1}
                              : '0;
  assign tx_shift     = (state == ADDR) || (state == WDATA);
  assign rx_shift     = ((state == RWAIT) || (state == RDATA)) && bus.svalid;

  piso_sipo_shift #(.WIDTH(TX_W)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data (tx_load_data),
    .shift     (tx_shift),
    .shift_in  (1'b0),
    .data      (tx_data)
  );

  // Only the first DATA_WIDTH-1 bits are held; the last one goes straight
  // into drdata on the completing edge.
  piso_sipo_shift #(.WIDTH(DATA_WIDTH - 1)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ({(DATA_WIDTH-1){1'b0}}),
    .shift     (rx_shift),
    .shift_in  (bus.srdata),
    .data      (rx_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= MODE_READ;
      dready_q  <= 1'b1;
      mvalid_q  <= 1'b0;
      mmode_q   <= 1'b0;
      drdata_q  <= '0;
      drvalid_q <= 1'b0;
      dack_q    <= 1'b0;
      derr_q    <= 1'b0;
    end else begin
      drvalid_q <= 1'b0;
      dack_q    <= 1'b0;
      derr_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.dreq) begin
            mode_q   <= bus.dmode;
            mmode_q  <= bus.dmode;
            mvalid_q <= 1'b1;
            dready_q <= 1'b0;
            cnt      <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (addr_end) begin
            cnt <= '0;
            if (mode_q == MODE_WRITE) begin
              state <= WDATA;
            end else begin
              mvalid_q <= 1'b0;
              mmode_q  <= 1'b0;
              state    <= RWAIT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WDATA: begin
          if (tx_last) begin
            mvalid_q <= 1'b0;
            mmode_q  <= 1'b0;
            dack_q   <= 1'b1;
            state    <= DONE;
          end
        end
        RWAIT: begin
          // A response in the very last wait cycle still wins over the timeout.
          if (bus.svalid) begin
            cnt   <= CNT_W'(1);
            state <= RDATA;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            dack_q <= 1'b1;
            derr_q <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RDATA: begin
          if (!bus.svalid) begin
            dack_q <= 1'b1;
            derr_q <= 1'b1;
            state  <= DONE;
          end else if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
            drdata_q  <= {rx_data, bus.srdata};
            drvalid_q <= 1'b1;
            dack_q    <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          cnt      <= '0;
          dready_q <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dready  = dready_q;
  assign bus.drdata  = drdata_q;
  assign bus.drvalid = drvalid_q;
  assign bus.dack    = dack_q;
  assign bus.derr    = derr_q;
  assign bus.mwdata  = tx_data[TX_W-1];
  assign bus.mmode   = mmode_q;
  assign bus.mvalid  = mvalid_q;

endmodule

// File: tb/tb_master_port.sv
// Randomised bench for master_port; expected wire activity is derived from
// the request and a scripted responder (start delay, bits supplied).
module tb_master_port;
  import master_port_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] last_read;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // {dready, mvalid, mmode, mwdata, dack, derr, drvalid}
  function automatic logic [6:0] out_vec();
    return {bus.dready, bus.mvalid, bus.mmode, bus.mwdata, bus.dack, bus.derr, bus.drvalid};
  endfunction

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      bus.svalid = 1'($urandom);
      bus.srdata = 1'($urandom);
      @(posedge clk); #1;
      checkOutput("idle", 32'(out_vec()), 32'(7'b1000000));
    end
  endtask

  // The responder starts answering in wait cycle 'delay' (none if >= TO) and
  // keeps svalid high for 'nbits' cycles; abort_j >= 0 pulses reset there.
  task automatic applyStimulus(input logic mode, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                               input int delay, input int nbits, input bit hold,
                               input int abort_j);
    int done_j;
    int i;
    bit err;
    logic [6:0] exp;
    logic [AW+DW-1:0] stream;
    stream = {addr, wdata};
    if (mode == MODE_WRITE) begin
      done_j = AW + DW; err = 1'b0;
    end else if (delay >= TO) begin
      done_j = AW + TO; err = 1'b1;
    end else if (nbits >= DW) begin
      done_j = AW + 1 + delay + DW - 1; err = 1'b0;
    end else begin
      done_j = AW + 1 + delay + nbits; err = 1'b1;
    end
    bus.dreq   = 1'b1;
    bus.dmode  = mode;
    bus.daddr  = addr;
    bus.dwdata = wdata;
    bus.svalid = 1'($urandom);
    bus.srdata = 1'($urandom);
    @(posedge clk); #1;
    for (int j = 0; j <= done_j; j++) begin
      if (j == done_j)
        exp = {4'b0000, 1'b1, err, (!err && mode == MODE_READ)};
      else if (j < AW || (mode == MODE_WRITE && j < AW + DW))
        exp = {1'b0, 1'b1, mode, stream[AW+DW-1-j], 3'b000};
      else
        exp = '0;
      checkOutput($sformatf("cycle%0d", j), 32'(out_vec()), 32'(exp));
      if (j == done_j) begin
        if (mode == MODE_READ && !err) last_read = rdata;
        checkOutput("drdata", 32'(bus.drdata), 32'(last_read));
      end
      if (j == abort_j) begin
        rst = 1'b1;
        bus.dreq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_read = '0;
        checkOutput("post_reset", 32'(out_vec()), 32'(7'b1000000));
        checkOutput("reset_drdata", 32'(bus.drdata), 32'(0));
        return;
      end
      if (!hold) bus.dreq = 1'b0;
      bus.daddr  = AW'($urandom);
      bus.dwdata = DW'($urandom);
      bus.dmode  = 1'($urandom);
      i = j - AW;
      if (mode == MODE_READ && i >= 0 && j < done_j) begin
        if (delay < TO && i >= delay && i < delay + nbits) begin
          bus.svalid = 1'b1;
          bus.srdata = rdata[DW-1-(i-delay)];
        end else begin
          bus.svalid = 1'b0;
          bus.srdata = 1'($urandom);
        end
      end else begin
        bus.svalid = 1'($urandom);
        bus.srdata = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    checkOutput("ready_after", 32'(out_vec()), 32'(7'b1000000));
    if (!hold) bus.dreq = 1'b0;
  endtask

  initial begin
    logic m;
    int dly;
    int nb;
    bit h;
    last_read  = '0;
    bus.dreq   = 1'b0;
    bus.dmode  = 1'b0;
    bus.daddr  = '0;
    bus.dwdata = '0;
    bus.svalid = 1'b0;
    bus.srdata = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'(out_vec()), 32'(7'b1000000));
    checkOutput("reset_drdata", 32'(bus.drdata), 32'(0));
    rst = 1'b0;
    idle_cycles(2);

    applyStimulus(MODE_WRITE, 12'h5AB, 8'hAA, 8'h00, 0, 0, 1'b0, -1);
    idle_cycles(2);
    applyStimulus(MODE_READ, 12'h5AB, 8'h00, 8'hCC, 5, DW, 1'b0, -1);
    idle_cycles(1);
    applyStimulus(MODE_READ, 12'h5AB, 8'h00, 8'h00, TO, 0, 1'b0, -1);
    applyStimulus(MODE_READ, 12'h3C7, 8'h00, 8'h5A, 2, 4, 1'b0, -1);
    applyStimulus(MODE_READ, 12'h0F0, 8'h00, 8'h96, TO - 1, DW, 1'b0, -1);
    applyStimulus(MODE_READ, 12'h123, 8'h00, 8'h3E, 0, DW, 1'b0, -1);
    applyStimulus(MODE_WRITE, 12'hABC, 8'h5D, 8'h00, 0, 0, 1'b0, AW + 3);
    idle_cycles(3);
    applyStimulus(MODE_WRITE, 12'h001, 8'h01, 8'h00, 0, 0, 1'b0, -1);
    applyStimulus(MODE_WRITE, 12'h3A5, 8'hC3, 8'h00, 0, 0, 1'b1, -1);
    applyStimulus(MODE_WRITE, 12'h65A, 8'h3C, 8'h00, 0, 0, 1'b0, -1);
    idle_cycles(1);

    for (int k = 0; k < 24; k++) begin
      m   = 1'($urandom);
      dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                        : int'($urandom_range(0, 10));
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW - 1)) : DW;
      h   = (k != 23) && ($urandom_range(0, 2) == 0);
      applyStimulus(m, AW'($urandom), DW'($urandom), DW'($urandom), dly, nb, h, -1);
      if (!h) idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
